uart_tx_word: RTL and testbench
===============================

# uart_tx_word

Transmit-side counterpart of the team's UART receiver. Accepts one 32-bit word over an AXI4-Stream-style input and serialises it as four 8N1 UART frames on `txd`. Byte order and bit timing match the receiver's word assembly, so a `uart_tx_word` → `uart_rx` loopback reproduces the word exactly on the receiver's `datas` output. Sits between the processor's output path and the board TX pin.

## Interface
- `PRESCALE`, default 8: bit period is `PRESCALE*8` clocks; 64 clocks at the default.
- `DATA_WIDTH`, default 8: byte width of each frame. Only 8 is supported.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `input_axis_tdata` input 32: word to transmit.
- `input_axis_tvalid` input 1: word valid.
- `input_axis_tready` output 1: block is idle and can accept a word.
- `txd` output 1: UART serial output; idle level is high.
- `busy` output 1: high from word acceptance until the last stop bit completes.
- `byte_done` output 1: one-cycle pulse at the end of each stop bit.

## Operation
- States: IDLE, START, DATA, STOP.
- Byte send order for word W: W[15:8], then W[7:0], then W[31:24], then W[23:16]. This is the inverse of the receiver's packing `{b2,b3,b0,b1}`.
- IDLE
  - `txd`=1, `busy`=0, `input_axis_tready`=1.
  - On `tvalid && tready`: latch W, set `byte_cnt`=0, load the shift register with byte 0, go to START.
- START: drive `txd`=0 for one bit period, then go to DATA with `bit_cnt`=0.
- DATA
  - Drive `txd`=shift[0], LSB first, for one bit period per bit.
  - After each bit: shift right and increment `bit_cnt`.
  - After bit 7, go to STOP.
- STOP: drive `txd`=1 for one bit period. At its final cycle, pulse `byte_done`, then:
  - if `byte_cnt`<3: increment `byte_cnt`, load the next byte, go to START;
  - else go to IDLE.
- Bit-period counter
  - 19-bit down-counter, loaded with `PRESCALE*8-1` on entry to each bit.
  - The bit ends when the counter reads 0.
  - Width rule: `PRESCALE*8-1` must fit in 19 bits.
- `tvalid` asserted outside IDLE is ignored, and `tdata` is not sampled. The latched word is immune to input changes mid-transmission.
- No parity and no inter-byte gap. The stop bit of byte n is followed directly by the start bit of byte n+1.
- Reset (`rst_n`=0 at a clock edge):
  - state goes to IDLE, all counters clear;
  - `txd`=1, `busy`=0, `byte_done`=0, `input_axis_tready`=0;
  - `tready` rises on the first edge after `rst_n` returns high.
- Reset mid-frame aborts immediately: `txd` returns high on the next edge and no partial byte is resumed.

## Timing
- Acceptance edge: `tready` drops to 0 and `busy` rises to 1 at that edge. The start bit appears on `txd` in the same registered update.
- Bit period: exactly `PRESCALE*8` cycles. The frame is 10 bit periods, 640 cycles at default.
- A word is 4 frames, 2560 cycles at default, from the first start-bit cycle to the last stop-bit cycle.
- `byte_done` is high for exactly the final cycle of each stop bit: 4 pulses per word, 640 cycles apart.
- After the 4th stop bit:
  - next cycle is IDLE, with `busy`=0 and `tready`=1;
  - the earliest next start bit is one cycle later, giving one extra idle-high clock between words;
  - with `tvalid` held high, back-to-back words therefore repeat every 2561 cycles.
- `txd` is driven from a flop, with no combinational path from inputs to `txd`.

## Test plan
- Reset, then W=0x12345678, `tvalid` for 1 cycle → bytes 0x56, 0x78, 0x12, 0x34 on `txd`, LSB first; each framed by start=0 and stop=1; each bit exactly 64 cycles; 4 `byte_done` pulses; `busy` high for 2560 cycles.
- Loopback into `uart_rx` with W=0xDEADBEEF → receiver `datas`=0xDEADBEEF after the 4th byte; `frame_error` never asserted.
- `tvalid` held high with W=0xAAAAAAAA, with `tdata` changed to 0x55555555 at cycle 100 → the first word transmits intact as 0xAA bytes; the second word (0x55555555) starts 2561 cycles after the first start bit.
- `rst_n` low for 1 cycle during the DATA state of byte 2 → `txd`=1 on the next edge; `busy`=0; `tready`=1 one cycle after release; no further transitions on `txd`.
- W=0x00000000 and W=0xFFFFFFFF → start and stop bits are still correct and exactly 64 cycles each, with no early termination on all-zero data.
- `tvalid` pulsed while `busy` → ignored; `tready` stays 0; the transmitted byte sequence is unchanged.

Source files
------------

// File: rtl/uart_tx_word.sv
// uart_tx_word: serialises one 32-bit word as four 8N1 UART frames, byte order {W[15:8],W[7:0],W[31:24],W[23:16]}.
module uart_tx_word #(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] input_axis_tdata,
  input  logic        input_axis_tvalid,
  output logic        input_axis_tready,
  output logic        txd,
  output logic        busy,
  output logic        byte_done
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [18:0] BIT_LAST = 19'(PRESCALE * 8 - 1);
  localparam logic [2:0]  BIT_MAX  = 3'(DATA_WIDTH - 1);
  state_t                  state_q;
  logic [31:0]             word_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [2:0]              bit_cnt_q;
  logic [1:0]              byte_cnt_q;
  logic [18:0]             cnt_q;
  logic                    txd_q, busy_q, tready_q, done_q;
  logic [DATA_WIDTH-1:0]   next_byte_d;
  // byte that follows the one currently being sent
  always_comb
    next_byte_d = byte_cnt_q == 2'd0 ? word_q[7:0] :
                  byte_cnt_q == 2'd1 ? word_q[31:24] : word_q[23:16];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      tready_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // registered so it is high during the last stop-bit cycle
      done_q <= state_q == STOP && cnt_q == 19'd1;
      case (state_q)
        IDLE: begin
          tready_q <= 1'b1;
          busy_q   <= 1'b0;
          txd_q    <= 1'b1;
          if (input_axis_tvalid && tready_q) begin
            word_q     <= input_axis_tdata;
            shift_q    <= input_axis_tdata[15:8];
            byte_cnt_q <= '0;
            cnt_q      <= BIT_LAST;
            txd_q      <= 1'b0;
            busy_q     <= 1'b1;
            tready_q   <= 1'b0;
            state_q    <= START;
          end
        end
        START: begin
          if (cnt_q == '0) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
            cnt_q     <= BIT_LAST;
            txd_q     <= shift_q[0];
          end else cnt_q <= cnt_q - 19'd1;
        end
        DATA: begin
          if (cnt_q == '0) begin
            cnt_q <= BIT_LAST;
            if (bit_cnt_q == BIT_MAX) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              txd_q     <= shift_q[1];
            end
          end else cnt_q <= cnt_q - 19'd1;
        end
        STOP: begin
          if (cnt_q == '0) begin
            if (byte_cnt_q != 2'd3) begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
              shift_q    <= next_byte_d;
              cnt_q      <= BIT_LAST;
              txd_q      <= 1'b0;
              state_q    <= START;
            end else begin
              txd_q    <= 1'b1;
              busy_q   <= 1'b0;
              tready_q <= 1'b1;
              state_q  <= IDLE;
            end
          end else cnt_q <= cnt_q - 19'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign txd               = txd_q;
  assign busy              = busy_q;
  assign byte_done         = done_q;
  assign input_axis_tready = tready_q;
endmodule

// File: tb/tb_uart_tx_word.sv
// tb_uart_tx_word: directed checks of framing, byte order, timing, back-to-back words and reset abort.
module tb_uart_tx_word;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tready, txd, busy, byte_done;
  int          total = 0;
  int          bad = 0;
  uart_tx_word dut (
    .clk(clk), .rst_n(rst_n),
    .input_axis_tdata(tdata), .input_axis_tvalid(tvalid), .input_axis_tready(tready),
    .txd(txd), .busy(busy), .byte_done(byte_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Called at a negedge while idle; exp holds the bytes in send order, byte 0 in [31:24].
  task automatic send_word(input logic [31:0] w, input logic [31:0] exp, input bit hold,
                           input bit poke, input logic [31:0] alt);
    tdata  = w;
    tvalid = 1'b1;
    chk("tready_idle", {31'd0, tready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    tvalid = hold;
    for (int f = 0; f < 4; f++) begin
      logic [7:0] eb, rx;
      int e;
      eb = exp[31 - 8*f -: 8];
      rx = '0;
      e  = 0;
      for (int b = 0; b < 10; b++) begin
        logic bit_exp;
        bit_exp = b == 0 ? 1'b0 : b == 9 ? 1'b1 : eb[b-1];
        for (int c = 0; c < 64; c++) begin
          if (txd !== bit_exp) e++;
          if (byte_done !== (b == 9 && c == 63)) e++;
          if (busy !== 1'b1 || tready !== 1'b0) e++;
          if (c == 32 && b >= 1 && b <= 8) rx[b-1] = txd;
          if (hold && f == 0 && b == 1 && c == 36) tdata = alt;
          if (poke && f == 1 && b == 3) begin
            tdata  = alt;
            tvalid = c < 5;
          end
          @(negedge clk);
        end
      end
      chk($sformatf("byte%0d", f), {24'd0, rx}, {24'd0, eb});
      chk($sformatf("frame%0d_errs", f), e, 0);
    end
    chk("idle_after", {29'd0, busy, tready, txd}, 32'd3);
  endtask
  initial begin
    int changes;
    logic last;
    repeat (3) @(negedge clk);
    chk("rst_state", {28'd0, txd, busy, tready, byte_done}, 32'b1000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_tready", {31'd0, tready}, 32'd1);
    send_word(32'h1234_5678, 32'h5678_1234, 1'b0, 1'b0, '0);
    send_word(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, '0);
    send_word(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
    send_word(32'hDEAD_BEEF, 32'hBEEF_DEAD, 1'b0, 1'b1, 32'h0F0F_0F0F);
    send_word(32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b1, 1'b0, 32'h5555_5555);
    send_word(32'h5555_5555, 32'h5555_5555, 1'b0, 1'b0, '0);
    // abort in the middle of byte 2's data bits
    tdata  = 32'h1234_5678;
    tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tvalid = 1'b0;
    repeat (1280 + 64 + 100) @(negedge clk);
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_state", {28'd0, txd, busy, tready, byte_done}, 32'b1000);
    @(negedge clk);
    chk("abort_tready", {31'd0, tready}, 32'd1);
    changes = 0;
    last    = txd;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (txd !== last || busy !== 1'b0) changes++;
      last = txd;
    end
    chk("abort_quiet", changes, 0);
    chk("abort_txd_high", {31'd0, txd}, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
